// File: rtl/collector_pkg.sv
// Shared state encoding and defaults for the bit batch collector.
package collector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FULL    = 2'd2
  } state_e;

  localparam int unsigned DROP_CNT_WIDTH_DEFAULT = 16;

  // Address width for a memory of the given depth, never narrower than one bit.
  function automatic int unsigned addr_width(int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/bit_batch_collector_if.sv
// Bit-source, batch-memory port A and transmit-stage handshake signals of the collector.
interface bit_batch_collector_if
  import collector_pkg::*;
#(
  parameter int unsigned MEM_ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned DROP_CNT_WIDTH = DROP_CNT_WIDTH_DEFAULT
);

  logic                      start;
  logic                      bit_valid;
  logic                      bit_in;
  logic                      batch_ack;
  logic                      wea;
  logic [MEM_ADDR_WIDTH-1:0] addra;
  logic [DATA_WIDTH-1:0]     dina;
  logic                      batch_ready;
  logic                      busy;
  logic [DROP_CNT_WIDTH-1:0] drop_count;

  modport master (
    output start, bit_valid, bit_in, batch_ack,
    input  wea, addra, dina, batch_ready, busy, drop_count
  );

  modport slave (
    input  start, bit_valid, bit_in, batch_ack,
    output wea, addra, dina, batch_ready, busy, drop_count
  );

endinterface

// File: rtl/bit_packer.sv
// MSB-first serial-to-parallel packer; flags the cycle in which a word's last bit arrives.
module bit_packer #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  bit_valid,
  input  logic                  bit_in,
  output logic                  word_valid,
  output logic [DATA_WIDTH-1:0] word
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

  // Only DATA_WIDTH-1 bits need storing; the final bit is taken straight from bit_in.
  logic [DATA_WIDTH-2:0] sr_q, sr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  assign word       = {sr_q, bit_in};
  assign word_valid = bit_valid && (cnt_q == LastBit);

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (clear) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (bit_valid) begin
      sr_d  = word[DATA_WIDTH-2:0];
      cnt_d = (cnt_q == LastBit) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bit_batch_collector.sv
// Packs serial entropy bits into words, writes a batch into memory port A and holds it
// until the transmit stage acknowledges; bits arriving while the buffer is full are counted.
module bit_batch_collector
  import collector_pkg::*;
#(
  parameter int unsigned BATCH_SIZE     = 1000,
  parameter int unsigned MEM_ADDR_WIDTH = addr_width(BATCH_SIZE),
  parameter int unsigned DATA_WIDTH     = 8,
  parameter bit          AUTO_RESTART   = 1'b1,
  parameter int unsigned DROP_CNT_WIDTH = DROP_CNT_WIDTH_DEFAULT
) (
  input logic                  clk,
  input logic                  rst_n,
  bit_batch_collector_if.slave bus
);

  localparam logic [MEM_ADDR_WIDTH-1:0] LastAddr = MEM_ADDR_WIDTH'(BATCH_SIZE - 1);

  state_e                    state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [MEM_ADDR_WIDTH-1:0] addra_q, addra_d;
  logic [DATA_WIDTH-1:0]     dina_q, dina_d;
  logic                      wea_q, wea_d;
  logic                      ready_q, ready_d;
  logic                      busy_q, busy_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;

  logic                  pack_valid;
  logic                  pack_clear;
  logic                  word_valid;
  logic [DATA_WIDTH-1:0] word;

  // The packer only sees bits while collecting, so IDLE and FULL bits never reach it.
  assign pack_valid = (state_q == ST_COLLECT) && bus.bit_valid;

  bit_packer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bit_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (pack_clear),
    .bit_valid  (pack_valid),
    .bit_in     (bus.bit_in),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    addra_d    = addra_q;
    dina_d     = dina_q;
    wea_d      = 1'b0;
    ready_d    = ready_q;
    drop_d     = drop_q;
    pack_clear = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (word_valid) begin
          wea_d   = 1'b1;
          addra_d = word_cnt_q;
          dina_d  = word;
          // Counter stops on the last address so it cannot wrap inside a batch.
          if (word_cnt_q == LastAddr) begin
            state_d = ST_FULL;
            ready_d = 1'b1;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      ST_FULL: begin
        if (bus.bit_valid && (drop_q != '1)) drop_d = drop_q + 1'b1;
        if (bus.batch_ack) begin
          ready_d    = 1'b0;
          word_cnt_d = '0;
          pack_clear = 1'b1;
          state_d    = AUTO_RESTART ? ST_COLLECT : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_COLLECT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      word_cnt_q <= '0;
      addra_q    <= '0;
      dina_q     <= '0;
      wea_q      <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      addra_q    <= addra_d;
      dina_q     <= dina_d;
      wea_q      <= wea_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
    end
  end

  assign bus.wea         = wea_q;
  assign bus.addra       = addra_q;
  assign bus.dina        = dina_q;
  assign bus.batch_ready = ready_q;
  assign bus.busy        = busy_q;
  assign bus.drop_count  = drop_q;

endmodule
